// File: rtl/calendar_set_ctrl.sv
// Date-setting front-panel controller: steps through day/month/year edit states,
// turns key events into increment pulses, holds back the midnight carry and blinks the edited field.
module calendar_set_ctrl #(
  parameter int BLINK_HALF = 25_000_000,
  parameter int HOLD_DLY   = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000,
  parameter int TIMEOUT    = 500_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       key_mode,
  input  logic       key_inc_p,
  input  logic       key_inc_lvl,
  input  logic       full_flag_in,
  output logic [2:0] cnt_inc,
  output logic       full_flag,
  output logic       set_mode,
  output logic [7:0] blink_mask
);

  localparam int BW = $clog2(BLINK_HALF) + 1;
  localparam int HW = $clog2(HOLD_DLY) + 1;
  localparam int RW = $clog2(RPT_PERIOD) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [BW-1:0] BLINK_C   = BW'(BLINK_HALF);
  localparam logic [HW-1:0] HOLD_C    = HW'(HOLD_DLY);
  localparam logic [RW-1:0] RPT_C     = RW'(RPT_PERIOD);
  localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    S_DAY  = 2'd1,
    S_MON  = 2'd2,
    S_YEAR = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [HW-1:0]   r_hold_cnt;
  logic [RW-1:0]   r_rpt_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_phase;
  logic            r_pend;
  logic [2:0]      r_cnt_inc;
  logic            r_full;
  logic            r_set_mode;
  logic [7:0]      r_blink_mask;

  logic            w_in_set;
  logic            w_active;
  logic            w_state_chg;
  logic            w_to_fire;
  logic [HW-1:0]   w_hold_inc;
  logic [RW-1:0]   w_rpt_inc;
  logic [BW-1:0]   w_blink_inc;
  logic            w_auto_ok;
  logic            w_hold_fire;
  logic            w_rpt_fire;
  logic            w_inc_fire;
  logic [2:0]      w_field_hot;
  logic [7:0]      w_field_mask;
  logic [BW-1:0]   w_blink_cnt_nxt;
  logic            w_phase_nxt;

  assign w_in_set    = (r_state != RUN);
  assign w_active    = key_mode | key_inc_p | key_inc_lvl;
  assign w_to_fire   = w_in_set && !w_active && (r_to_cnt == TO_LAST_C);
  assign w_state_chg = (w_state_nxt != r_state);

  assign w_hold_inc  = r_hold_cnt + HW'(1);
  assign w_rpt_inc   = r_rpt_cnt + RW'(1);
  assign w_blink_inc = r_blink_cnt + BW'(1);

  // Auto-repeat: first pulse when the hold count reaches HOLD_DLY, then every RPT_PERIOD cycles.
  assign w_auto_ok   = w_in_set && key_inc_lvl;
  assign w_hold_fire = w_auto_ok && (r_hold_cnt != HOLD_C) && (w_hold_inc == HOLD_C);
  assign w_rpt_fire  = w_auto_ok && (r_hold_cnt == HOLD_C) && (w_rpt_inc == RPT_C);
  assign w_inc_fire  = w_in_set && !key_mode && (key_inc_p || w_hold_fire || w_rpt_fire);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (key_mode) w_state_nxt = S_DAY;
        else          w_state_nxt = RUN;
      end
      S_DAY: begin
        if (key_mode)       w_state_nxt = S_MON;
        else if (w_to_fire) w_state_nxt = RUN;
        else                w_state_nxt = S_DAY;
      end
      S_MON: begin
        if (key_mode)       w_state_nxt = S_YEAR;
        else if (w_to_fire) w_state_nxt = RUN;
        else                w_state_nxt = S_MON;
      end
      S_YEAR: begin
        if (key_mode)       w_state_nxt = RUN;
        else if (w_to_fire) w_state_nxt = RUN;
        else                w_state_nxt = S_YEAR;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_field_hot = 3'b000;
    case (r_state)
      S_DAY:   w_field_hot = 3'b001;
      S_MON:   w_field_hot = 3'b010;
      S_YEAR:  w_field_hot = 3'b100;
      default: w_field_hot = 3'b000;
    endcase
  end

  always_comb begin
    w_field_mask = 8'h00;
    case (w_state_nxt)
      S_DAY:   w_field_mask = 8'h03;
      S_MON:   w_field_mask = 8'h0C;
      S_YEAR:  w_field_mask = 8'hF0;
      default: w_field_mask = 8'h00;
    endcase
  end

  // Phase restarts visible on entry and on each increment so the edited digits stay readable.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    if ((w_state_nxt == RUN) || w_state_chg || w_inc_fire) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b0;
    end else if (w_blink_inc == BLINK_C) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = ~r_phase;
    end else begin
      w_blink_cnt_nxt = w_blink_inc;
      w_phase_nxt     = r_phase;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hold_cnt <= '0;
      r_rpt_cnt  <= '0;
    end else if (!w_in_set || w_state_chg || !key_inc_lvl) begin
      r_hold_cnt <= '0;
      r_rpt_cnt  <= '0;
    end else if (r_hold_cnt != HOLD_C) begin
      r_hold_cnt <= w_hold_inc;
      r_rpt_cnt  <= '0;
    end else if (w_rpt_inc == RPT_C) begin
      r_rpt_cnt  <= '0;
    end else begin
      r_rpt_cnt  <= w_rpt_inc;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_to_cnt <= '0;
    end else if (!w_in_set || w_active || w_to_fire) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Carries seen while editing collapse into one pulse released on the first RUN cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_full <= 1'b0;
      r_pend <= 1'b0;
    end else if (!w_in_set) begin
      r_full <= full_flag_in | r_pend;
      r_pend <= 1'b0;
    end else begin
      r_full <= 1'b0;
      r_pend <= r_pend | full_flag_in;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_blink_mask <= 8'h00;
    end else begin
      r_blink_cnt  <= w_blink_cnt_nxt;
      r_phase      <= w_phase_nxt;
      r_blink_mask <= w_phase_nxt ? w_field_mask : 8'h00;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt_inc  <= 3'b000;
      r_set_mode <= 1'b0;
    end else begin
      r_cnt_inc  <= w_inc_fire ? w_field_hot : 3'b000;
      r_set_mode <= (w_state_nxt != RUN);
    end
  end

  assign cnt_inc    = r_cnt_inc;
  assign full_flag  = r_full;
  assign set_mode   = r_set_mode;
  assign blink_mask = r_blink_mask;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Directed bench for calendar_set_ctrl with shortened timing parameters.
module tb_calendar_set_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       key_mode = 1'b0;
  logic       key_inc_p = 1'b0;
  logic       key_inc_lvl = 1'b0;
  logic       full_flag_in = 1'b0;
  logic [2:0] cnt_inc;
  logic       full_flag;
  logic       set_mode;
  logic [7:0] blink_mask;

  int n_checks = 0;
  int n_fail = 0;

  calendar_set_ctrl #(
    .BLINK_HALF(4),
    .HOLD_DLY(10),
    .RPT_PERIOD(3),
    .TIMEOUT(40)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .key_mode(key_mode),
    .key_inc_p(key_inc_p),
    .key_inc_lvl(key_inc_lvl),
    .full_flag_in(full_flag_in),
    .cnt_inc(cnt_inc),
    .full_flag(full_flag),
    .set_mode(set_mode),
    .blink_mask(blink_mask)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    key_mode = 1'b0; key_inc_p = 1'b0; key_inc_lvl = 1'b0; full_flag_in = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic pulse_mode();
    key_mode = 1'b1;
    tick();
    key_mode = 1'b0;
  endtask

  task automatic pulse_inc();
    key_inc_p = 1'b1;
    tick();
    key_inc_p = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cnt_inc, full_flag, set_mode, blink_mask} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cnt_inc=%b full_flag=%b set_mode=%b blink_mask=%h, want all 0",
               cnt_inc, full_flag, set_mode, blink_mask);
    end
    Reset = 1'b0;
    tick();
    n_checks++;
    if ({cnt_inc, full_flag, set_mode, blink_mask} !== 13'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got cnt_inc=%b full_flag=%b set_mode=%b blink_mask=%h, want all 0",
               cnt_inc, full_flag, set_mode, blink_mask);
    end
  endtask

  task automatic test_mode_cycle();
    logic [3:0] exp_sm;
    exp_sm = 4'b0111;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_mode();
      n_checks++;
      if (set_mode !== exp_sm[i]) begin
        n_fail++;
        $display("FAIL mode_step%0d_set_mode: got %b want %b", i, set_mode, exp_sm[i]);
      end
      n_checks++;
      if (cnt_inc !== 3'b000) begin
        n_fail++;
        $display("FAIL mode_step%0d_cnt_inc: got %b want 000", i, cnt_inc);
      end
      tick();
    end
  endtask

  task automatic test_manual_inc();
    apply_reset();
    pulse_mode();
    pulse_mode();
    for (int i = 0; i < 3; i++) begin
      pulse_inc();
      n_checks++;
      if (cnt_inc !== 3'b010) begin
        n_fail++;
        $display("FAIL mon_inc%0d_pulse: got %b want 010", i, cnt_inc);
      end
      tick();
      n_checks++;
      if (cnt_inc !== 3'b000) begin
        n_fail++;
        $display("FAIL mon_inc%0d_width: got %b want 000", i, cnt_inc);
      end
    end
    pulse_mode();
    pulse_mode();
    pulse_inc();
    n_checks++;
    if (cnt_inc !== 3'b000) begin
      n_fail++;
      $display("FAIL run_inc_ignored: got %b want 000", cnt_inc);
    end
  endtask

  task automatic test_auto_repeat();
    logic [2:0] exp_ci;
    apply_reset();
    pulse_mode();
    pulse_mode();
    pulse_mode();
    key_inc_p = 1'b1;
    key_inc_lvl = 1'b1;
    tick();
    key_inc_p = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      exp_ci = (c == 1 || c == 10 || c == 13 || c == 16 || c == 19) ? 3'b100 : 3'b000;
      n_checks++;
      if (cnt_inc !== exp_ci) begin
        n_fail++;
        $display("FAIL auto_repeat_cycle%0d: got %b want %b", c, cnt_inc, exp_ci);
      end
      key_inc_lvl = (c < 20);
      tick();
    end
  endtask

  task automatic test_carry();
    logic exp_ff;
    apply_reset();
    full_flag_in = 1'b1;
    tick();
    full_flag_in = 1'b0;
    n_checks++;
    if (full_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL run_carry_pass: got %b want 1", full_flag);
    end
    tick();
    n_checks++;
    if (full_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL run_carry_width: got %b want 0", full_flag);
    end
    pulse_mode();
    for (int i = 0; i < 2; i++) begin
      full_flag_in = 1'b1;
      tick();
      full_flag_in = 1'b0;
      tick();
      n_checks++;
      if (full_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL set_carry_gated%0d: got %b want 0", i, full_flag);
      end
    end
    pulse_mode();
    pulse_mode();
    pulse_mode();
    for (int c = 0; c < 5; c++) begin
      exp_ff = (c == 1);
      n_checks++;
      if (full_flag !== exp_ff) begin
        n_fail++;
        $display("FAIL release_carry_cycle%0d: got %b want %b", c, full_flag, exp_ff);
      end
      tick();
    end
    pulse_mode();
    full_flag_in = 1'b1;
    tick();
    full_flag_in = 1'b0;
    pulse_mode();
    pulse_mode();
    pulse_mode();
    full_flag_in = 1'b1;
    tick();
    full_flag_in = 1'b0;
    for (int c = 1; c < 4; c++) begin
      exp_ff = (c == 1);
      n_checks++;
      if (full_flag !== exp_ff) begin
        n_fail++;
        $display("FAIL merge_carry_cycle%0d: got %b want %b", c, full_flag, exp_ff);
      end
      tick();
    end
  endtask

  task automatic test_blink_timeout();
    logic [7:0] exp_mask;
    apply_reset();
    pulse_mode();
    for (int c = 0; c < 40; c++) begin
      exp_mask = (((c / 4) % 2) == 1) ? 8'h03 : 8'h00;
      n_checks++;
      if (blink_mask !== exp_mask || set_mode !== 1'b1) begin
        n_fail++;
        $display("FAIL blink_cycle%0d: got mask=%h set_mode=%b want mask=%h set_mode=1",
                 c, blink_mask, set_mode, exp_mask);
      end
      tick();
    end
    n_checks++;
    if (set_mode !== 1'b0 || blink_mask !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_exit: got set_mode=%b mask=%h want 0 and 00", set_mode, blink_mask);
    end
    pulse_inc();
    n_checks++;
    if (cnt_inc !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_in_run: got cnt_inc=%b want 000", cnt_inc);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pulse_mode();
    pulse_mode();
    key_mode = 1'b1;
    key_inc_p = 1'b1;
    tick();
    key_mode = 1'b0;
    key_inc_p = 1'b0;
    n_checks++;
    if (cnt_inc !== 3'b000 || set_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_wins: got cnt_inc=%b set_mode=%b want 000 and 1", cnt_inc, set_mode);
    end
    tick();
    pulse_inc();
    n_checks++;
    if (cnt_inc !== 3'b100) begin
      n_fail++;
      $display("FAIL state_is_year: got cnt_inc=%b want 100", cnt_inc);
    end
    full_flag_in = 1'b1;
    tick();
    full_flag_in = 1'b0;
    Reset = 1'b1;
    #2;
    n_checks++;
    if ({cnt_inc, full_flag, set_mode, blink_mask} !== 13'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got cnt_inc=%b full_flag=%b set_mode=%b mask=%h want all 0",
               cnt_inc, full_flag, set_mode, blink_mask);
    end
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (full_flag !== 1'b0 || set_mode !== 1'b0) begin
        n_fail++;
        $display("FAIL discard_pending%0d: got full_flag=%b set_mode=%b want 0 0", c, full_flag, set_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_manual_inc();
    test_auto_repeat();
    test_carry();
    test_blink_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
